// File: rtl/ncl_rca_pipe.sv
// Dual-rail (NULL Convention) ripple-carry adder, pipelined in CHUNK-bit slices with ko/ki handshakes.
// Define NCL_ADD_CHECK_EN to build illegal-code (11) detection with a sticky err flag; otherwise err is 0.
module ncl_rca_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [1:0]         c_in,
  input  logic               ki,
  output logic               ko,
  output logic [2*WIDTH-1:0] s,
  output logic [1:0]         c_out,
  output logic               err
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  typedef enum logic {RFD, RFN} in_state_t;
  typedef enum logic {NUL, DAT} out_state_t;

  in_state_t  r_in_state,  w_in_next;
  out_state_t r_out_state, w_out_next;

  logic [WIDTH-1:0]  w_a_val, w_b_val;
  logic              w_data, w_null, w_cap;
  logic [STAGES-1:0] w_valid, w_go;
  logic [WIDTH-1:0]  w_last_sum;
  logic              w_last_cy;

  // Wavefront classification; the true rail carries the single-rail value.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_data = c_in[1] ^ c_in[0];
    w_null = ~(c_in[1] | c_in[0]);
    for (int i = 0; i < WIDTH; i++) begin
      w_a_val[i] = a[2*i+1];
      w_b_val[i] = b[2*i+1];
      if (!(a[2*i+1] ^ a[2*i]) || !(b[2*i+1] ^ b[2*i])) w_data = 1'b0;
      if (a[2*i+1] | a[2*i] | b[2*i+1] | b[2*i])        w_null = 1'b0;
    end
  end

  // Emptying chain, resolved from the output end so a freed slot can refill in the same cycle.
  always_comb begin
    logic v_go;
    w_go       = '0;
    v_go       = en && (r_out_state == DAT) && !ki;
    w_go[LAST] = v_go;
    for (int k = LAST - 1; k >= 0; k--) begin
      v_go    = en && w_valid[k] && (!w_valid[k+1] || v_go);
      w_go[k] = v_go;
    end
  end

  assign w_cap = en && (r_in_state == RFD) && w_data && (!w_valid[0] || w_go[0]);
  assign ko    = (r_in_state == RFD) && !w_valid[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * CHUNK;

    logic [SRC_W-1:0]         w_src_a, w_src_b;
    logic                     w_src_cy, w_load;
    logic [CHUNK:0]           w_chunk;
    logic [(k+1)*CHUNK-1:0]   w_next_sum;
    logic [(k+1)*CHUNK-1:0]   r_sum;
    logic                     r_cy;
    logic                     r_valid;

    if (k == 0) begin : g_head
      assign w_src_a    = w_a_val;
      assign w_src_b    = w_b_val;
      assign w_src_cy   = c_in[1];
      assign w_load     = w_cap;
      assign w_next_sum = w_chunk[CHUNK-1:0];
    end else begin : g_body
      assign w_src_a    = g_stage[k-1].g_rem.r_rem_a;
      assign w_src_b    = g_stage[k-1].g_rem.r_rem_b;
      assign w_src_cy   = g_stage[k-1].r_cy;
      assign w_load     = w_go[k-1];
      assign w_next_sum = {w_chunk[CHUNK-1:0], g_stage[k-1].r_sum};
    end

    assign w_chunk = {1'b0, w_src_a[CHUNK-1:0]} + {1'b0, w_src_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, w_src_cy};
    assign w_valid[k] = r_valid;

    always_ff @(posedge clk) begin
      if (rst)           r_valid <= 1'b0;
      else if (w_load)   r_valid <= 1'b1;
      else if (w_go[k])  r_valid <= 1'b0;
    end

    // NOTE: payload registers carry no reset; the valid bit alone decides whether they mean anything.
    always_ff @(posedge clk) begin
      if (w_load) begin
        r_sum <= w_next_sum;
        r_cy  <= w_chunk[CHUNK];
      end
    end

    // Operand bits not yet consumed travel with the token to later slices.
    if (k < LAST) begin : g_rem
      logic [SRC_W-CHUNK-1:0] r_rem_a, r_rem_b;
      always_ff @(posedge clk) begin
        if (w_load) begin
          r_rem_a <= w_src_a[SRC_W-1:CHUNK];
          r_rem_b <= w_src_b[SRC_W-1:CHUNK];
        end
      end
    end

    if (k == LAST) begin : g_out
      assign w_last_sum = r_sum;
      assign w_last_cy  = r_cy;
    end
  end

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      RFD:     if (w_cap)          w_in_next = RFN;
      RFN:     if (en && w_null)   w_in_next = RFD;
      default:                     w_in_next = RFD;
    endcase
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      NUL:     if (en && ki && w_valid[LAST]) w_out_next = DAT;
      DAT:     if (en && !ki)                 w_out_next = NUL;
      default:                                w_out_next = NUL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_state  <= RFD;
      r_out_state <= NUL;
    end else begin
      r_in_state  <= w_in_next;
      r_out_state <= w_out_next;
    end
  end

  always_comb begin
    s     = '0;
    c_out = '0;
    if (r_out_state == DAT) begin
      for (int i = 0; i < WIDTH; i++) begin
        s[2*i+1] = w_last_sum[i];
        s[2*i]   = ~w_last_sum[i];
      end
      c_out = {w_last_cy, ~w_last_cy};
    end
  end

`ifdef NCL_ADD_CHECK_EN
  logic w_ill;
  logic r_err;

  always_comb begin
    w_ill = &c_in;
    for (int i = 0; i < WIDTH; i++) begin
      if ((a[2*i+1] & a[2*i]) | (b[2*i+1] & b[2*i])) w_ill = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                r_err <= 1'b0;
    else if (en && w_ill)   r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_rca_pipe.sv
// Directed bench for ncl_rca_pipe (WIDTH=8, CHUNK=4): handshake, latency, back-pressure, errors, reset, freeze.
module tb_ncl_rca_pipe;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  c_in;
  logic        ki;
  logic        ko;
  logic [15:0] s;
  logic [1:0]  c_out;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [1:0] C0 = 2'b01;
  localparam logic [1:0] C1 = 2'b10;
`ifdef NCL_ADD_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  ncl_rca_pipe #(.WIDTH(8), .CHUNK(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .ki    (ki),
    .ko    (ko),
    .s     (s),
    .c_out (c_out),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dr8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] va, input logic [15:0] vb, input logic [1:0] vc);
    a    = va;
    b    = vb;
    c_in = vc;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ki = 1'b0;
    put(16'h0, 16'h0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    chk("rst_ko",    16'(ko),    16'd1);
    chk("rst_s",     s,          16'h0);
    chk("rst_cout",  16'(c_out), 16'h0);
    chk("rst_err",   16'(err),   16'h0);

    // Basic sum 0x5A + 0x33 = 0x8D
    ki = 1'b1;
    put(dr8(8'h5A), dr8(8'h33), C0);
    tick();
    chk("basic_ko_fall",  16'(ko), 16'd0);
    chk("basic_s_e0",     s,       16'h0);
    tick();
    chk("basic_s_e1",     s,       16'h0);
    tick();
    chk("basic_s",        s,          dr8(8'h8D));
    chk("basic_cout",     16'(c_out), 16'(C0));
    chk("basic_ko_held",  16'(ko),    16'd0);
    put(16'h0, 16'h0, 2'b00);
    tick();
    chk("basic_ko_rise",  16'(ko), 16'd1);
    ki = 1'b0;
    tick();
    chk("basic_s_null",   s,          16'h0);
    chk("basic_c_null",   16'(c_out), 16'h0);

    // Full carry ripple 0xFF + 0x01 + 1 = 0x101
    ki = 1'b1;
    put(dr8(8'hFF), dr8(8'h01), C1);
    tick(); tick(); tick();
    chk("ripple_s",     s,          dr8(8'h01));
    chk("ripple_cout",  16'(c_out), 16'(C1));
    put(16'h0, 16'h0, 2'b00);
    tick();
    chk("ripple_ko",    16'(ko), 16'd1);
    ki = 1'b0;
    tick();
    chk("ripple_null",  s, 16'h0);

    // Back-pressure: ki held low, three wavefronts offered
    put(dr8(8'h01), dr8(8'h02), C0);
    tick();
    put(16'h0, 16'h0, 2'b00);
    tick();
    chk("bp_ko_after1", 16'(ko), 16'd1);
    put(dr8(8'h10), dr8(8'h20), C0);
    tick();
    chk("bp_ko_cap2",   16'(ko), 16'd0);
    put(16'h0, 16'h0, 2'b00);
    tick();
    chk("bp_ko_full",   16'(ko), 16'd0);
    put(dr8(8'h40), dr8(8'h04), C0);
    tick();
    chk("bp_third_blk", 16'(ko), 16'd0);
    tick();
    chk("bp_third_blk2", 16'(ko), 16'd0);
    ki = 1'b1;
    tick();
    chk("bp_res1",      s, dr8(8'h03));
    ki = 1'b0;
    tick();
    chk("bp_null1",     s,       16'h0);
    chk("bp_third_cap", 16'(ko), 16'd0);
    ki = 1'b1;
    tick();
    chk("bp_res2",      s, dr8(8'h30));
    ki = 1'b0;
    tick();
    chk("bp_null2",     s, 16'h0);
    put(16'h0, 16'h0, 2'b00);
    ki = 1'b1;
    tick();
    chk("bp_res3",      s,       dr8(8'h44));
    chk("bp_ko_empty",  16'(ko), 16'd1);
    ki = 1'b0;
    tick();
    chk("bp_null3",     s, 16'h0);

    // Illegal code on pair 0 of a
    put(dr8(8'h11) | 16'h0003, dr8(8'h22), C0);
    tick();
    chk("ill_err",       16'(err), 16'(EXP_ERR));
    chk("ill_no_cap",    16'(ko),  16'd1);
    tick();
    chk("ill_no_cap2",   16'(ko),  16'd1);
    put(dr8(8'h11), dr8(8'h22), C0);
    tick();
    chk("ill_fixed_cap", 16'(ko),  16'd0);
    chk("ill_sticky",    16'(err), 16'(EXP_ERR));
    put(16'h0, 16'h0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ill_rst_err",   16'(err), 16'h0);
    chk("ill_rst_ko",    16'(ko),  16'd1);

    // Reset one cycle after capture discards the token
    ki = 1'b1;
    put(dr8(8'h10), dr8(8'h20), C0);
    tick();
    put(16'h0, 16'h0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ko",   16'(ko),    16'd1);
    chk("mid_rst_s",    s,          16'h0);
    chk("mid_rst_cout", 16'(c_out), 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_never", s, 16'h0);
    end

    // Freeze with en low while DAT shows 0x8D and ki falls
    put(dr8(8'h5A), dr8(8'h33), C0);
    tick(); tick(); tick();
    chk("frz_s",      s, dr8(8'h8D));
    put(16'h0, 16'h0, 2'b00);
    tick();
    chk("frz_ko",     16'(ko), 16'd1);
    en = 1'b0;
    ki = 1'b0;
    tick();
    chk("frz_hold1",  s, dr8(8'h8D));
    tick();
    chk("frz_hold2",  s,          dr8(8'h8D));
    chk("frz_cout",   16'(c_out), 16'(C0));
    put(dr8(8'h01), dr8(8'h01), C0);
    tick();
    chk("frz_no_cap", 16'(ko), 16'd1);
    put(16'h0, 16'h0, 2'b00);
    en = 1'b1;
    tick();
    chk("frz_release", s, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
